// File: rtl/seg_code_pkg.sv
// Shared code constants, enums and pure helpers for the seven-segment code sequencer.
// Holds the double-dabble step and the six-digit layout composer.
package seg_code_pkg;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;
    localparam logic [3:0] CODE_P     = 4'd12;
    localparam logic [3:0] CODE_R     = 4'd13;
    localparam logic [3:0] CODE_E     = 4'd14;
    localparam logic [3:0] CODE_F     = 4'd15;

    typedef enum logic [1:0] {
        MODE_SCORE = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_FINAL = 2'd2,
        MODE_BLANK = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV_L  = 2'd1,
        CONV_R  = 2'd2,
        COMPOSE = 2'd3
    } state_t;

    // One double-dabble step: add-3 correction on each nibble, then shift in the next bit.
    // Inputs are clamped to 99, so the tens nibble never carries out.
    function automatic logic [7:0] dd_step(input logic [7:0] bcd, input logic bit_in);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = bcd[7:4];
        ones = bcd[3:0];
        if (tens >= 4'd5) tens = tens + 4'd3;
        if (ones >= 4'd5) ones = ones + 4'd3;
        return {tens[2:0], ones, bit_in};
    endfunction

    function automatic logic [3:0] tens_code(input logic [3:0] tens);
        return (tens == 4'd0) ? CODE_BLANK : tens;
    endfunction

    function automatic logic [23:0] compose_codes(input mode_t mode, input logic winner,
                                                  input logic [7:0] bcd_l, input logic [7:0] bcd_r);
        logic [23:0] codes;
        case (mode)
            MODE_SCORE: codes = {tens_code(bcd_l[7:4]), bcd_l[3:0], CODE_DASH, CODE_DASH,
                                 tens_code(bcd_r[7:4]), bcd_r[3:0]};
            MODE_PAUSE: codes = {CODE_P, CODE_R, CODE_E, CODE_BLANK, CODE_BLANK, CODE_BLANK};
            MODE_FINAL: codes = {CODE_F, CODE_DASH, CODE_P, (winner ? 4'd2 : 4'd1),
                                 CODE_BLANK, CODE_BLANK};
            MODE_BLANK: codes = {6{CODE_BLANK}};
            default:    codes = {6{CODE_BLANK}};
        endcase
        return codes;
    endfunction

endpackage

// File: rtl/seg_code_sequencer_bin2bcd_seq.sv
// Sequential 7-bit binary to two-digit BCD converter, one bit per clock.
// The start edge performs the first shift, so a conversion takes exactly 7 edges.
module bin2bcd_seq
    import seg_code_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic [7:0] bcd,
    output logic       done
);

    logic [6:0] sr_r;
    logic [7:0] bcd_r;
    logic [2:0] cnt_r;
    logic       active_r;

    // done marks the edge that performs the final shift; bcd is valid right after it.
    assign done = active_r && (cnt_r == 3'd1);
    assign bcd  = bcd_r;

    // Shift register, BCD accumulator and remaining-shift counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_r     <= 7'd0;
            bcd_r    <= 8'd0;
            cnt_r    <= 3'd0;
            active_r <= 1'b0;
        end else if (start) begin
            bcd_r    <= dd_step(8'd0, bin[6]);
            sr_r     <= {bin[5:0], 1'b0};
            cnt_r    <= 3'd6;
            active_r <= 1'b1;
        end else if (active_r) begin
            bcd_r    <= dd_step(bcd_r, sr_r[6]);
            sr_r     <= {sr_r[5:0], 1'b0};
            cnt_r    <= cnt_r - 3'd1;
            active_r <= (cnt_r != 3'd1);
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_code_sequencer.sv
// Builds six 4-bit display codes from two Pong scores and a game mode.
// One shared BCD converter serves left then right score; codes update atomically.
module seg_code_sequencer
    import seg_code_pkg::*;
#(
    parameter int SCORE_W   = 7,
    parameter int MAX_SCORE = 99
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SCORE_W-1:0] score_l,
    input  logic [SCORE_W-1:0] score_r,
    input  logic [1:0]         mode,
    input  logic               winner,
    input  logic               update,
    output logic               busy,
    output logic               done,
    output logic [23:0]        hex_code
);

    function automatic logic [6:0] clamp_score(input logic [SCORE_W-1:0] s);
        if (s > SCORE_W'(MAX_SCORE)) return 7'(MAX_SCORE);
        else                         return 7'(s);
    endfunction

    state_t      state_r, state_next_s;
    logic        latch_en_s, conv_start_s, capture_l_s, compose_en_s, go_next_s;
    logic        go_r, pending_r, busy_r, done_r, lat_winner_r;
    mode_t       lat_mode_r;
    logic [6:0]  lat_l_r, lat_r_r;
    logic [6:0]  conv_bin_s;
    logic [7:0]  conv_bcd_s, bcd_l_r;
    logic        conv_done_s;
    logic [23:0] hex_code_r;

    assign conv_bin_s = (state_r == CONV_L) ? lat_l_r : lat_r_r;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start_s),
        .bin     (conv_bin_s),
        .bcd     (conv_bcd_s),
        .done    (conv_done_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_next_s;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        latch_en_s   = 1'b0;
        conv_start_s = 1'b0;
        capture_l_s  = 1'b0;
        compose_en_s = 1'b0;
        go_next_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (update || pending_r) begin
                    latch_en_s   = 1'b1;
                    go_next_s    = 1'b1;
                    state_next_s = CONV_L;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONV_L: begin
                conv_start_s = go_r;
                if (conv_done_s) begin
                    go_next_s    = 1'b1;
                    state_next_s = CONV_R;
                end else begin
                    state_next_s = CONV_L;
                end
            end
            CONV_R: begin
                // The left result is still on the converter output when the right one starts.
                conv_start_s = go_r;
                capture_l_s  = go_r;
                if (conv_done_s) state_next_s = COMPOSE;
                else             state_next_s = CONV_R;
            end
            COMPOSE: begin
                compose_en_s = 1'b1;
                state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Latched request, pending flag, left BCD holding register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            go_r         <= 1'b0;
            pending_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            lat_l_r      <= 7'd0;
            lat_r_r      <= 7'd0;
            lat_mode_r   <= MODE_BLANK;
            lat_winner_r <= 1'b0;
            bcd_l_r      <= 8'd0;
            hex_code_r   <= {6{CODE_BLANK}};
        end else begin
            go_r   <= go_next_s;
            done_r <= compose_en_s;
            if (latch_en_s) begin
                lat_l_r      <= clamp_score(score_l);
                lat_r_r      <= clamp_score(score_r);
                lat_mode_r   <= mode_t'(mode);
                lat_winner_r <= winner;
                pending_r    <= 1'b0;
                busy_r       <= 1'b1;
            end else begin
                if (update) pending_r <= 1'b1;
                if (compose_en_s) busy_r <= 1'b0;
            end
            if (capture_l_s) bcd_l_r <= conv_bcd_s;
            if (compose_en_s)
                hex_code_r <= compose_codes(lat_mode_r, lat_winner_r, bcd_l_r, conv_bcd_s);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign hex_code = hex_code_r;

endmodule

// File: tb/tb_seg_code_sequencer.sv
// Scoreboard bench: stimulus pushes expected codes and due cycles; a negedge monitor checks each done.
module tb_seg_code_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  score_l = 7'd0, score_r = 7'd0;
    logic [1:0]  mode = 2'd0;
    logic        winner = 1'b0;
    logic        update = 1'b0;
    logic        busy, done;
    logic [23:0] hex_code;

    typedef struct { logic [23:0] hex; int due; } exp_t;
    exp_t q[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int done_count = 0;
    int n_edge;

    seg_code_sequencer #(.SCORE_W(7), .MAX_SCORE(99)) dut (
        .clk(clk), .reset_n(reset_n), .score_l(score_l), .score_r(score_r),
        .mode(mode), .winner(winner), .update(update),
        .busy(busy), .done(done), .hex_code(hex_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue a one-cycle update; returns 1ns after the sampling edge with n_edge set.
    task automatic do_update(input logic [6:0] l, input logic [6:0] r, input logic [1:0] m,
                             input logic w, input bit push, input logic [23:0] exp_hex);
        exp_t e;
        @(negedge clk);
        score_l = l; score_r = r; mode = m; winner = w; update = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        n_edge = cyc;
        if (push) begin
            e.hex = exp_hex; e.due = n_edge + 15;
            q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: timeout with %0d outstanding, required 0", name, q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    logic [23:0] prev_hex;
    logic        prev_done = 1'b0;

    // Monitor: every done pulse pops one expectation; codes must not move between pulses.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (done) begin
                done_count++;
                check("done_width", {31'd0, prev_done}, 32'd0);
                check("busy_in_done", {31'd0, busy}, 32'd0);
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("hex_code", {8'd0, hex_code}, {8'd0, e.hex});
                    check("latency", cyc, e.due);
                end
            end else if (cyc > 2) begin
                check("hold", {8'd0, hex_code}, {8'd0, prev_hex});
            end
        end
        prev_hex  = hex_code;
        prev_done = done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hex", {8'd0, hex_code}, 32'h00AAAAAA);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
        end

        // Basic score with busy window check.
        do_update(7'd7, 7'd12, 2'd0, 1'b0, 1'b1, 24'hA7BB12);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("busy_window", {31'd0, busy}, 32'd1);
        end
        wait_drain("score_7_12");

        do_update(7'd120, 7'd0, 2'd0, 1'b0, 1'b1, 24'h99BBA0);
        wait_drain("score_clamp");
        do_update(7'd3, 7'd9, 2'd2, 1'b1, 1'b1, 24'hFBC2AA);
        wait_drain("final_w1");
        do_update(7'd3, 7'd9, 2'd2, 1'b0, 1'b1, 24'hFBC1AA);
        wait_drain("final_w0");
        do_update(7'd0, 7'd0, 2'd1, 1'b0, 1'b1, 24'hCDEAAA);
        wait_drain("pause");
        do_update(7'd50, 7'd60, 2'd3, 1'b0, 1'b1, 24'hAAAAAA);
        wait_drain("blank");
        do_update(7'd99, 7'd10, 2'd0, 1'b0, 1'b1, 24'h99BB10);
        wait_drain("score_99_10");

        // Pending: requests at N+3 and N+5 merge into one, latched at N+16.
        dc = done_count;
        do_update(7'd3, 7'd4, 2'd0, 1'b0, 1'b1, 24'hA3BBA4);
        begin
            exp_t e2;
            e2.hex = 24'hA5BBA6; e2.due = n_edge + 31;
            q.push_back(e2);
        end
        repeat (2) @(negedge clk);
        do_update(7'd5, 7'd6, 2'd0, 1'b0, 1'b0, 24'h0);
        @(negedge clk);
        do_update(7'd5, 7'd6, 2'd0, 1'b0, 1'b0, 24'h0);
        wait_drain("pending");
        repeat (20) @(negedge clk);
        check("pending_done_count", done_count - dc, 32'd2);

        // Reset mid-conversion abandons the request.
        do_update(7'd7, 7'd12, 2'd0, 1'b0, 1'b1, 24'hA7BB12);
        wait_drain("pre_reset");
        check("pre_reset_hex", {8'd0, hex_code}, 32'h00A7BB12);
        dc = done_count;
        do_update(7'd55, 7'd66, 2'd0, 1'b0, 1'b0, 24'h0);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_hex", {8'd0, hex_code}, 32'h00AAAAAA);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check("reset_no_done", done_count - dc, 32'd0);
        check("reset_hold_hex", {8'd0, hex_code}, 32'h00AAAAAA);
        do_update(7'd45, 7'd8, 2'd0, 1'b0, 1'b1, 24'h45BBA8);
        wait_drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_code_sequencer.md
Name: seg_code_sequencer

Overview:
- Producer side of the 7-segment path: builds the 4-bit display codes that the per-digit segment decoders (HEX5..HEX0) consume.
- Converts two binary Pong scores to BCD with a sequential double-dabble.
- Composes a six-digit layout selected by game mode: score, pause, final/winner, or blank.
- Updates all six digit codes atomically and pulses done once per completed update.

Parameters:
- SCORE_W, 7, width of each binary score input.
- MAX_SCORE, 99, saturation value; latched scores above it are clamped to it.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- score_l  in  SCORE_W  left player score, binary
- score_r  in  SCORE_W  right player score, binary
- mode  in  2  0 SCORE, 1 PAUSE, 2 FINAL, 3 BLANK
- winner  in  1  0 left, 1 right; used in FINAL only
- update  in  1  request; sampled every clk
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse when new codes are presented
- hex_code  out  24  six 4-bit codes; [23:20] HEX5 (leftmost) down to [3:0] HEX0

Behaviour:
- Code map:
  - 0-9 digits; 10 blank; 11 '-'; 12 'P'; 13 'r.'; 14 'E.'; 15 'F'.
- Reset (reset_n low at a clk edge):
  - hex_code = all 10 (0xAAAAAA); busy=0, done=0, pending=0; FSM -> IDLE.
  - Applies from any state; a conversion in progress is abandoned and its results are never shown.
- FSM states:
  - IDLE: update=1 or pending=1 -> latch score_l, score_r (each clamped to MAX_SCORE), mode and winner; clear pending; -> CONV_L.
  - CONV_L: 7 shift cycles of double-dabble on latched score_l -> CONV_R.
  - CONV_R: 7 shift cycles on latched score_r -> COMPOSE.
  - COMPOSE: register all six hex_code nibbles in one cycle; done=1 in the following cycle; -> IDLE.
- Latency:
  - update sampled at edge N in IDLE -> hex_code changes at edge N+15; done high for exactly the cycle after N+15.
  - busy=1 from edge N to edge N+15; busy is low in the cycle done is high.
- All modes traverse CONV_L/CONV_R, so latency is mode-independent (15 edges).
- Layouts, HEX5..HEX0:
  - SCORE: Ltens, Lones, 11, 11, Rtens, Rones. A tens digit of 0 is replaced by 10 (leading blank); ones is always shown.
  - PAUSE: 12, 13, 14, 10, 10, 10.
  - FINAL: 15, 11, 12, (winner ? 2 : 1), 10, 10.
  - BLANK: all 10.
- update while busy:
  - Sets pending (one-deep; repeated requests merge).
  - Inputs are not captured at that time; they are sampled when IDLE next latches.
  - The pending request starts in the cycle after done, so the second request is latched at edge N+16 and its codes appear at N+31.
- update held high continuously: back-to-back conversions, one per 16 cycles.
- hex_code holds its last value between updates; it never shows partial results.

Decomposition:
- Package seg_code_pkg:
  - Code constants CODE_BLANK=10, CODE_DASH=11, CODE_P=12, CODE_R=13, CODE_E=14, CODE_F=15.
  - typedef enum mode_t {MODE_SCORE, MODE_PAUSE, MODE_FINAL, MODE_BLANK}.
  - typedef enum state_t {IDLE, CONV_L, CONV_R, COMPOSE}.
- Sub-module bin2bcd_seq: 7-bit in, 8-bit BCD out (tens, ones), start/done handshake, 7 cycles. It is instantiated once and reused sequentially for score_l, then score_r.

Test Plan:
- Reset then idle: hex_code=0xAAAAAA, busy=0, done=0 for 20 cycles with update=0.
- SCORE, score_l=7, score_r=12, one-cycle update at edge N -> at N+15 hex_code=0xA7BB12; done high for one cycle only; busy high for edges N..N+14.
- SCORE, score_l=120, score_r=0 -> hex_code=0x99BBA0 (clamp to 99; right tens blanked, ones shows 0).
- FINAL, winner=1 -> hex_code=0xFBC2AA. Then PAUSE -> hex_code=0xCDEAAA.
- Update at N (score 3/4), update pulses at N+3 and N+5 with score 5/6 -> first done shows 0xA3BBA4 at N+15; second done shows 0xA5BBA6 at N+31; exactly two done pulses.
- reset_n low at N+8 mid-conversion (prior codes 0xA7BB12) -> hex_code=0xAAAAAA; no done pulse; busy=0; next update completes normally.
